// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial two's-complement adder/subtractor. It accepts one operation per
// start, processes one bit per clock LSB first, and presents the result
// together with a one-cycle done pulse.
//
// Subtraction is addition of the inverted B operand. The initial carry is
// cin ^ sub, so cin acts as a carry-in for add and as a borrow-in for sub:
//   add: s = a + b + cin
//   sub: s = a + ~b + !cin = a - b - cin   (mod 2^WIDTH)
// In sub mode cout = 1 means "no borrow".
//
// Handshake: start is sampled only while the FSM is in IDLE. The operands a,
// b, sub and cin are captured on that same edge. start seen in RUN or DONE is
// dropped. busy is high for exactly WIDTH cycles (RUN). done is high for
// exactly one cycle (DONE), and s/cout/ovf are valid from then on. They hold
// until the next result or a reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request a new operation (IDLE only)
//   sub        in   0 = add, 1 = subtract
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (add) / borrow-in (sub)
//   busy       out  high while the operation is in progress
//   done       out  one-cycle result-valid pulse
//   s          out  WIDTH-bit result
//   cout       out  final carry out (sub: 1 = no borrow)
//   ovf        out  two's-complement overflow
//   state_dbg  out  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;     // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q, b_d;     // B ^ {WIDTH{sub}}, shifted right likewise
  logic             c_q, c_d;     // running carry into the current bit
  logic [WIDTH-1:0] r_q, r_d;     // partial result, sum bits enter at the MSB
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Full-adder cell as a 3-to-8 decoder.
  // The minterm index is {A[i], B'[i], c}. Sum is the odd-parity minterms.
  // Carry is the minterms with two or more ones.
  // ---------------------------------------------------------------------------
  logic [2:0] fa_idx;
  logic [7:0] minterm;
  logic       fa_sum;
  logic       fa_carry;

  assign fa_idx = {a_q[0], b_q[0], c_q};

  always_comb begin
    minterm = '0;
    for (int k = 0; k < 8; k++) begin
      minterm[k] = (fa_idx == 3'(k));
    end
  end

  assign fa_sum   = minterm[1] | minterm[2] | minterm[4] | minterm[7];
  assign fa_carry = minterm[3] | minterm[5] | minterm[6] | minterm[7];

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    r_d     = r_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = cin ^ sub;
          cnt_d   = '0;
          r_d     = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_carry;
        r_d   = {fa_sum, r_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // This edge processes the MSB. c_q is the carry into the MSB and
          // fa_carry is the carry out of it. Their XOR is signed overflow.
          s_d     = {fa_sum, r_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          ovf_d   = c_q ^ fa_carry;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      r_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Scoreboard bench for serial_addsub. It uses two instances: WIDTH=8 and
// WIDTH=4.
//
// Drivers change inputs on the falling edge. Monitors sample 1 ns after the
// rising edge. When an operation is issued, the driver pushes the expected
// {ovf, cout, s} into exp*_q and the accepting edge number into st*_q. The
// monitor pops both on every done pulse and checks:
//   - the result,
//   - the latency (WIDTH edges),
//   - the busy length (WIDTH cycles).
// Between results, the outputs must hold their last value. The reference
// model is plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- WIDTH = 8 instance ----------------
  logic       rst8, start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  logic [1:0] state8;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .s(s8), .cout(cout8),
    .ovf(ovf8), .state_dbg(state8)
  );

  // ---------------- WIDTH = 4 instance ----------------
  logic       rst4, start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] s4;
  logic [1:0] state4;

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .s(s4), .cout(cout4),
    .ovf(ovf4), .state_dbg(state4)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp8_q[$];
  int         st8_q[$];
  logic [9:0] last8 = '0;
  int         busy_cnt8 = 0;

  logic [5:0] exp4_q[$];
  int         st4_q[$];
  logic [5:0] last4 = '0;
  int         busy_cnt4 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model.
  // Returns {ovf, cout, s[63:0]} for a w-bit add/sub, computed arithmetically.
  function automatic logic [65:0] ref_model(input int w, input logic sb,
                                            input longint unsigned aa,
                                            input longint unsigned bb,
                                            input logic cc);
    longint r, sa, sbv, sr, lim, sres;
    logic   co, ov;
    lim = longint'(1) << (w - 1);
    r   = sb ? (longint'(aa) - longint'(bb) - longint'(cc))
             : (longint'(aa) + longint'(bb) + longint'(cc));
    sa  = (longint'(aa) >= lim) ? longint'(aa) - 2 * lim : longint'(aa);
    sbv = (longint'(bb) >= lim) ? longint'(bb) - 2 * lim : longint'(bb);
    sr  = sb ? (sa - sbv - longint'(cc)) : (sa + sbv + longint'(cc));
    ov  = (sr >= lim) || (sr < -lim);
    co  = sb ? (r >= 0) : (r >= 2 * lim);
    sres = r & (2 * lim - 1);
    return {ov, co, 64'(sres)};
  endfunction

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    logic [9:0] e;
    int         sc;
    #1;
    if (rst8) begin
      last8     = '0;
      busy_cnt8 = 0;
      check("reset_outputs8", 64'({busy8, done8, ovf8, cout8, s8}), 0);
    end else begin
      if (busy8) busy_cnt8++;
      if (done8) begin
        if (exp8_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done8: got done=1, expected no result pending (cycle %0d)", cyc);
        end else begin
          e  = exp8_q.pop_front();
          sc = st8_q.pop_front();
          check("result8", 64'({ovf8, cout8, s8}), 64'(e));
          check("latency8", cyc - sc, 8);
          check("busy_cycles8", busy_cnt8, 8);
          last8 = e;
        end
        busy_cnt8 = 0;
      end else begin
        check("hold8", 64'({ovf8, cout8, s8}), 64'(last8));
      end
    end
  end

  always @(posedge clk) begin
    logic [5:0] e;
    int         sc;
    #1;
    if (rst4) begin
      last4     = '0;
      busy_cnt4 = 0;
      check("reset_outputs4", 64'({busy4, done4, ovf4, cout4, s4}), 0);
    end else begin
      if (busy4) busy_cnt4++;
      if (done4) begin
        if (exp4_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done4: got done=1, expected no result pending (cycle %0d)", cyc);
        end else begin
          e  = exp4_q.pop_front();
          sc = st4_q.pop_front();
          check("result4", 64'({ovf4, cout4, s4}), 64'(e));
          check("latency4", cyc - sc, 4);
          check("busy_cycles4", busy_cnt4, 4);
          last4 = e;
        end
        busy_cnt4 = 0;
      end else begin
        check("hold4", 64'({ovf4, cout4, s4}), 64'(last4));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call with the DUT in IDLE (or entering IDLE before the next rising edge).
  task automatic issue8(input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                        input logic cc, input bit push);
    logic [65:0] m;
    @(negedge clk);
    start8 = 1'b1; sub8 = sb; a8 = aa; b8 = bb; cin8 = cc;
    if (push) begin
      m = ref_model(8, sb, 64'(aa), 64'(bb), cc);
      exp8_q.push_back({m[65:64], m[7:0]});
      st8_q.push_back(cyc + 1);
    end
    @(negedge clk);
    // Scramble the inputs after acceptance. They must have no effect.
    start8 = 1'b0;
    sub8 = 1'($urandom); cin8 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
    if (!done8) begin
      n_chk++;
      n_fail++;
      $display("FAIL done8_timeout: got no done within 20 cycles, expected done (cycle %0d)", cyc);
    end
  endtask

  task automatic issue4(input logic sb, input logic [3:0] aa, input logic [3:0] bb,
                        input logic cc);
    logic [65:0] m;
    @(negedge clk);
    start4 = 1'b1; sub4 = sb; a4 = aa; b4 = bb; cin4 = cc;
    m = ref_model(4, sb, 64'(aa), 64'(bb), cc);
    exp4_q.push_back({m[65:64], m[3:0]});
    st4_q.push_back(cyc + 1);
    @(negedge clk);
    start4 = 1'b0;
    sub4 = 1'($urandom); cin4 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 20 && !done4; i++) @(negedge clk);
    if (!done4) begin
      n_chk++;
      n_fail++;
      $display("FAIL done4_timeout: got no done within 20 cycles, expected done (cycle %0d)", cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [65:0] m;
    rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    check("idle_state8", 64'(state8), 0);
    check("idle_busy8", 64'(busy8), 0);

    // Directed vectors with hand-computed expectations.
    issue8(1'b0, 8'h3C, 8'h55, 1'b0, 1'b1);
    wait_done8();
    check("add_3c_55", 64'({ovf8, cout8, s8}), 64'({1'b1, 1'b0, 8'h91}));

    issue8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done8();
    check("add_ff_01", 64'({ovf8, cout8, s8}), 64'({1'b0, 1'b1, 8'h00}));

    issue8(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    wait_done8();
    check("sub_10_20", 64'({ovf8, cout8, s8}), 64'({1'b0, 1'b0, 8'hF0}));

    issue8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done8();
    check("sub_80_01", 64'({ovf8, cout8, s8}), 64'({1'b1, 1'b1, 8'h7F}));

    // start pulsed three cycles into RUN with new operands: it must be dropped.
    issue8(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'hAA; b8 = 8'hBB; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    check("ignored_start_result", 64'(s8), 64'(8'h46));
    repeat (12) @(negedge clk);

    // Reset in the third RUN cycle aborts the operation.
    issue8(1'b0, 8'h3C, 8'h55, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy8", 64'(busy8), 0);
    check("abort_outputs8", 64'({done8, ovf8, cout8, s8}), 0);
    repeat (12) @(negedge clk);
    check("abort_idle_state8", 64'(state8), 0);

    issue8(1'b0, 8'h3C, 8'h55, 1'b0, 1'b1);
    wait_done8();
    check("after_abort_result", 64'({ovf8, cout8, s8}), 64'({1'b1, 1'b0, 8'h91}));

    // Back-to-back: start held high, second op accepted two edges after done.
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1;
    m = ref_model(8, 1'b0, 64'(8'h01), 64'(8'h02), 1'b1);
    exp8_q.push_back({m[65:64], m[7:0]});
    st8_q.push_back(cyc + 1);
    wait_done8();
    sub8 = 1'b1; a8 = 8'h05; b8 = 8'h09; cin8 = 1'b1;
    m = ref_model(8, 1'b1, 64'(8'h05), 64'(8'h09), 1'b1);
    exp8_q.push_back({m[65:64], m[7:0]});
    st8_q.push_back(cyc + 2);
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    check("b2b_second_result", 64'({ovf8, cout8, s8}), 64'({1'b0, 1'b0, 8'hFB}));

    // Randomized operations on the 8-bit instance.
    for (int i = 0; i < 40; i++) begin
      issue8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done8();
    end

    // 4-bit instance.
    issue4(1'b0, 4'h7, 4'h1, 1'b1);
    wait_done4();
    check("w4_add_7_1_1", 64'({ovf4, cout4, s4}), 64'({1'b1, 1'b0, 4'h9}));
    for (int i = 0; i < 20; i++) begin
      issue4(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_done4();
    end

    repeat (4) @(negedge clk);
    check("exp8_q_drained", exp8_q.size(), 0);
    check("exp4_q_drained", exp4_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..64.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-006 SHALL have port sub, input, 1: 0 = add, 1 = subtract; sampled with start.
REQ-007 SHALL have port a, input, WIDTH: operand A; sampled with start.
REQ-008 SHALL have port b, input, WIDTH: operand B; sampled with start.
REQ-009 SHALL have port cin, input, 1: carry-in (add) or borrow-in (sub); sampled with start.
REQ-010 SHALL have port busy, output, 1: high while in RUN.
REQ-011 SHALL have port done, output, 1: one-cycle pulse; result valid.
REQ-012 SHALL have port s, output, WIDTH: result.
REQ-013 SHALL have port cout, output, 1: final carry out; in sub mode 1 = no borrow.
REQ-014 SHALL have port ovf, output, 1: two's-complement overflow.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: on a clock edge with start=1, SHALL latch a, b^{WIDTH{sub}}, and initial carry = cin^sub; SHALL clear the bit counter and enter RUN.
REQ-017 IDLE: with start=0, SHALL remain in IDLE.
REQ-018 RUN: each edge SHALL compute one bit, LSB first: bit i = A[i] xor B'[i] xor c; next c = majority(A[i], B'[i], c).
REQ-019 Full-adder bit logic SHALL be built as a 3-to-8 decoder with sum = OR of minterms 1,2,4,7 and carry = OR of minterms 3,5,6,7.
REQ-020 SHALL keep the bit counter ceil(log2(WIDTH)) bits wide; on the edge that processes bit WIDTH-1, SHALL enter DONE.
REQ-021 On entry to DONE, SHALL update s, cout and ovf together; ovf = carry into MSB xor carry out of MSB.
REQ-022 Latency: SHALL assert done in the cycle immediately after the WIDTH-th rising edge following the start-sampling edge.
REQ-023 busy SHALL be high for exactly WIDTH cycles per operation.
REQ-024 DONE: SHALL hold done=1 for one cycle, then enter IDLE unconditionally.
REQ-025 start asserted in RUN or DONE SHALL be ignored; no queueing.
REQ-026 Back-to-back operation: start held high SHALL be accepted again on the first IDLE edge, giving a throughput of one op per WIDTH+2 cycles.
REQ-027 s, cout and ovf SHALL hold their last result until the next DONE entry; changes to a, b, sub or cin after acceptance SHALL have no effect.
REQ-028 Sub mode SHALL compute a - b - cin modulo 2^WIDTH.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, s=0, cout=0, ovf=0, and the counter and internal registers to 0.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst during RUN or DONE SHALL abort the operation with no done pulse and no result update.

Verification
REQ-032 WIDTH=8, add, a=0x3C, b=0x55, cin=0 -> s=0x91, cout=0, ovf=1; done exactly 8 edges after the start edge; busy high 8 cycles.
REQ-033 WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, ovf=0.
REQ-034 WIDTH=8, sub, a=0x10, b=0x20, cin=0 -> s=0xF0, cout=0, ovf=0; then sub, a=0x80, b=0x01 -> s=0x7F, cout=1, ovf=1.
REQ-035 WIDTH=8, start pulsed again 3 cycles into RUN with new operands -> ignored; first result unchanged; only one done pulse.
REQ-036 WIDTH=8, rst asserted at RUN cycle 3 -> next cycle busy=0, s=0, cout=0, ovf=0; no done pulse; a following operation completes normally.
REQ-037 WIDTH=4, add, a=0x7, b=0x1, cin=1 -> s=0x9, cout=0, ovf=1; done 4 edges after the start edge.
